ppu_stream: RTL

- Post-processing unit directly downstream of the matrix-multiply controller.
- Prefetches a tile's bias values on a bias request, then consumes an AD-cycle burst of VL-lane accumulator vectors.
- Each lane: adds the column bias, rescales by an arithmetic right shift with rounding, saturates to OUT_W and writes one VL-lane output word per cycle to the output RAM.
- In a max pass it only tracks the matrix-wide max |acc+bias|, from which the calc-pass shift is derived.

---
 rtl/ppu_stream.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_stream.sv
// ppu_stream: tile bias prefetch (ping-pong), bias add, rounding shift, saturation, max tracking.
// Optional build macro PPU_RELU_EN: clamp negative results to zero and track max(sum, 0).
module ppu_stream #(
  parameter int VL     = 8,
  parameter int AD     = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 12,
  parameter int N_COLS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mtrx_start,
  input  logic                  i_max_pass,
  input  logic                  i_dyn_shift,
  input  logic [4:0]            i_shift,
  input  logic                  i_bias_req,
  input  logic [ACC_W-1:0]      i_bias_data,
  output logic                  o_bias_rd,
  output logic [ADDR_W-1:0]     o_bias_addr,
  input  logic                  i_ppu_start,
  input  logic [VL*ACC_W-1:0]   i_acc_data,
  output logic                  o_out_we,
  output logic [ADDR_W-1:0]     o_out_addr,
  output logic [VL*OUT_W-1:0]   o_out_data,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int CW = $clog2(AD);
  localparam int FW = $clog2(AD + 1);
  localparam int SW = ACC_W + 1;
  localparam logic [FW-1:0]     F_END  = FW'(AD);
  localparam logic [CW-1:0]     C_LAST = CW'(AD - 1);
  localparam logic [ADDR_W-1:0] COL_AD = ADDR_W'(AD);
  localparam logic [ADDR_W-1:0] COL_N  = ADDR_W'(N_COLS);
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));

  typedef enum logic {F_IDLE, F_FETCH} fstate_t;
  typedef enum logic {S_IDLE, S_RUN}   sstate_t;

  fstate_t f_state, f_next;
  sstate_t s_state, s_next;

  logic [FW-1:0]     f_cnt;
  logic              cap_vld;
  logic [CW-1:0]     cap_idx;
  logic [ADDR_W-1:0] col_base;
  logic [1:0]        full, full_nx;
  logic              wr_ptr, rd_ptr;
  logic [ACC_W-1:0]  bank [2][AD];

  logic [CW-1:0]     s_cnt;
  logic              s_use_bias, s_max_pass;

  logic                 s1_vld, s1_max;
  logic signed [SW-1:0] s1_sum [VL];
  logic signed [SW-1:0] sum_d  [VL];
  logic [ACC_W-1:0]     bias_sel;

  logic [ACC_W-1:0]   max_abs, max_cand;
  logic [ADDR_W-1:0]  wr_addr;
  logic [VL*OUT_W-1:0] out_d;
  logic [4:0]         sh, dyn_sh;
  int unsigned        msb;

  logic fetch_go, fetch_err, issue, cap_last;
  logic stream_go, stream_err, s_last;

  always_comb begin
    fetch_go   = (f_state == F_IDLE) && i_bias_req && !(&full);
    fetch_err  = i_bias_req && ((f_state == F_FETCH) || (&full));
    issue      = (f_state == F_FETCH) && (f_cnt != F_END);
    cap_last   = cap_vld && (cap_idx == C_LAST);
    stream_go  = (s_state == S_IDLE) && i_ppu_start;
    stream_err = i_ppu_start && ((s_state == S_RUN) || !full[rd_ptr]);
    s_last     = (s_state == S_RUN) && (s_cnt == C_LAST);

    f_next = f_state;
    case (f_state)
      F_IDLE:  if (fetch_go) f_next = F_FETCH;
      F_FETCH: if (cap_last) f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase

    s_next = s_state;
    case (s_state)
      S_IDLE:  if (stream_go) s_next = S_RUN;
      S_RUN:   if (s_last)    s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase

    o_bias_rd   = issue;
    o_bias_addr = col_base + ADDR_W'(f_cnt);

    // A stream that started without a filled bank never owned one, so it releases nothing.
    full_nx = full;
    if (cap_last)               full_nx[wr_ptr] = 1'b1;
    if (s_last && s_use_bias)   full_nx[rd_ptr] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_state    <= F_IDLE;
      s_state    <= S_IDLE;
      f_cnt      <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      col_base   <= '0;
      full       <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      s_cnt      <= '0;
      s_use_bias <= 1'b0;
      s_max_pass <= 1'b0;
      o_err      <= 1'b0;
    end else if (i_mtrx_start) begin
      f_state    <= F_IDLE;
      s_state    <= S_IDLE;
      f_cnt      <= '0;
      cap_vld    <= 1'b0;
      col_base   <= '0;
      full       <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      s_cnt      <= '0;
      o_err      <= 1'b0;
    end else begin
      f_state <= f_next;
      s_state <= s_next;
      if (fetch_go)   f_cnt <= '0;
      else if (issue) f_cnt <= f_cnt + 1'b1;
      cap_vld <= issue;
      cap_idx <= f_cnt[CW-1:0];
      if (cap_last) begin
        wr_ptr   <= ~wr_ptr;
        col_base <= (col_base + COL_AD >= COL_N) ? '0 : col_base + COL_AD;
      end
      full <= full_nx;
      if (stream_go) begin
        s_cnt      <= '0;
        s_use_bias <= full[rd_ptr];
        s_max_pass <= i_max_pass;
      end else if (s_state == S_RUN) begin
        s_cnt <= s_cnt + 1'b1;
      end
      if (s_last && s_use_bias) rd_ptr <= ~rd_ptr;
      if (fetch_err || stream_err) o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (cap_vld) bank[wr_ptr][cap_idx] <= i_bias_data;
  end

  always_comb begin
    bias_sel = s_use_bias ? bank[rd_ptr][s_cnt] : '0;
    for (int unsigned i = 0; i < VL; i++) begin
      sum_d[i] = $signed({i_acc_data[i*ACC_W + ACC_W - 1], i_acc_data[i*ACC_W +: ACC_W]})
               + $signed({bias_sel[ACC_W-1], bias_sel});
    end
  end

  always_comb begin
    msb = 0;
    for (int unsigned i = 0; i < ACC_W; i++) begin
      if (max_abs[i]) msb = i;
    end
    dyn_sh = (msb + 2 > OUT_W) ? 5'(msb + 2 - OUT_W) : '0;
  end

  // Datapath math is done in 64 bits so every shift amount up to 31 rounds correctly.
  always_comb begin
    logic signed [63:0] rnd, ext, t;
    logic [SW-1:0]      mag, lane_max;
    sh       = i_dyn_shift ? dyn_sh : i_shift;
    rnd      = (sh == '0) ? '0 : (64'sd1 <<< (sh - 5'd1));
    ext      = '0;
    t        = '0;
    mag      = '0;
    lane_max = '0;
    out_d    = '0;
    for (int unsigned i = 0; i < VL; i++) begin
      ext = {{(64 - SW){s1_sum[i][SW-1]}}, s1_sum[i]};
      t   = (ext + rnd) >>> sh;
`ifdef PPU_RELU_EN
      if (t < 0) t = '0;
      mag = s1_sum[i][SW-1] ? '0 : s1_sum[i];
`else
      mag = s1_sum[i][SW-1] ? -s1_sum[i] : s1_sum[i];
`endif
      if (t > SAT_MAX)      t = SAT_MAX;
      else if (t < SAT_MIN) t = SAT_MIN;
      out_d[i*OUT_W +: OUT_W] = t[OUT_W-1:0];
      if (mag > lane_max) lane_max = mag;
    end
    max_cand = lane_max[SW-1] ? '1 : lane_max[ACC_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld     <= 1'b0;
      s1_max     <= 1'b0;
      for (int unsigned i = 0; i < VL; i++) s1_sum[i] <= '0;
      o_out_we   <= 1'b0;
      o_out_addr <= '0;
      o_out_data <= '0;
      wr_addr    <= '0;
      max_abs    <= '0;
    end else if (i_mtrx_start) begin
      s1_vld     <= 1'b0;
      o_out_we   <= 1'b0;
      o_out_addr <= '0;
      wr_addr    <= '0;
      max_abs    <= '0;
    end else begin
      s1_vld <= (s_state == S_RUN);
      s1_max <= s_max_pass;
      for (int unsigned i = 0; i < VL; i++) s1_sum[i] <= sum_d[i];
      o_out_we <= s1_vld && !s1_max;
      if (s1_vld && !s1_max) begin
        o_out_data <= out_d;
        o_out_addr <= wr_addr;
        wr_addr    <= wr_addr + 1'b1;
      end
      if (s1_vld && s1_max && (max_cand > max_abs)) max_abs <= max_cand;
    end
  end

  assign o_busy = (f_state == F_FETCH) || (s_state == S_RUN) || s1_vld || o_out_we;

endmodule
